// File: rtl/nerv_axi_sram.sv
// nerv_axi_sram: AXI4 slave SRAM serving NERV cache line fills and write-backs.
// Word-addressed, byte-writable; one outstanding burst per direction.
//
// Ports:
//   clock, resetn          clock, asynchronous active-low reset
//   axi_aw* / axi_w* / axi_b*   write address, data and response channels
//   axi_ar* / axi_r*            read address and data channels
// Parameters:
//   DEPTH_LOG2  log2 of the memory size in 32-bit words
//   MAX_LEN     largest legal burst length in beats (AxLEN+1)
// Build option:
//   NERV_AXI_SRAM_STALL_EN  LFSR-driven ready/valid stalls (max 3 in a row)
module nerv_axi_sram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_LEN    = 2
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_awvalid,
    output logic        axi_awready,

    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,

    output logic        axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,

    input  logic        axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arvalid,
    output logic        axi_arready,

    output logic        axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    function automatic logic req_bad(
        input logic [1:0] lo,
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        req_bad = (burst != 2'b01) ||
                  (size != 3'd2) ||
                  ((int'(len) + 1) > MAX_LEN) ||
                  (lo != 2'b00);
    endfunction

    // Upper address bits beyond the memory size are ignored.
    logic unused_addr;
    assign unused_addr = ^{axi_awaddr[31:DEPTH_LOG2+2],
                           axi_araddr[31:DEPTH_LOG2+2]};

    // ------------------------------------------------------------
    // Stall source
    // ------------------------------------------------------------
    logic stall;
`ifdef NERV_AXI_SRAM_STALL_EN
    logic [15:0] lfsr_q;
    logic [1:0]  run_q;

    // The run counter forces a free cycle after 3 stalled ones.
    assign stall = lfsr_q[0] && (run_q != 2'd3);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 16'hACE1;
            run_q  <= 2'd0;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                       lfsr_q[15:1]};
            run_q  <= stall ? run_q + 2'd1 : 2'd0;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------
    // Storage (never reset)
    // ------------------------------------------------------------
    logic [31:0] mem_q [WORDS];
    logic        mem_we;
    idx_t        widx_q;
    idx_t        rd_idx;
    logic [31:0] rword;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) begin
                    mem_q[widx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Sampled before this edge's write lands: read-before-write.
    assign rword = mem_q[rd_idx];

    // ------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------
    w_state_e    w_state_q, w_state_d;
    idx_t        widx_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [8:0]  wbeat_q, wbeat_d;
    logic        werr_q, werr_d;
    logic        bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        aw_hs, w_hs, b_hs;
    logic        beyond;

    assign aw_hs = axi_awvalid && awready_q;
    assign w_hs  = axi_wvalid && wready_q;
    assign b_hs  = axi_bready && bvalid_q;

    always_comb begin
        w_state_d = w_state_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        beyond    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    bid_d     = axi_awid;
                    widx_d    = axi_awaddr[DEPTH_LOG2+1:2];
                    wlen_d    = axi_awlen;
                    wbeat_d   = '0;
                    werr_d    = req_bad(axi_awaddr[1:0], axi_awlen,
                                        axi_awsize, axi_awburst);
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    beyond = wbeat_q > {1'b0, wlen_q};
                    mem_we = !werr_q && !beyond;
                    widx_d = widx_q + idx_t'(1);
                    if (wbeat_q != 9'h1FF) begin
                        wbeat_d = wbeat_q + 9'd1;
                    end
                    if (beyond ||
                        (axi_wlast && (wbeat_q < {1'b0, wlen_q})) ||
                        (!axi_wlast && (wbeat_q == {1'b0, wlen_q}))) begin
                        werr_d = 1'b1;
                    end
                    if (axi_wlast) begin
                        w_state_d = W_RESP;
                        bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // Outputs are registered from the next state; bvalid, once
        // raised, holds until accepted.
        awready_d = (w_state_d == W_IDLE) && !stall;
        wready_d  = (w_state_d == W_DATA) && !stall;
        bvalid_d  = (w_state_d == W_RESP) &&
                    ((bvalid_q && !b_hs) || !stall);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            bid_q     <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;

    // ------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------
    r_state_e    r_state_q, r_state_d;
    idx_t        ridx_q, ridx_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [7:0]  rbeat_q, rbeat_d;
    logic        rerr_q, rerr_d;
    logic        rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rlast_q, rlast_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        ar_hs, r_hs;
    logic        ar_bad;

    assign ar_hs  = axi_arvalid && arready_q;
    assign r_hs   = axi_rready && rvalid_q;
    assign ar_bad = req_bad(axi_araddr[1:0], axi_arlen,
                            axi_arsize, axi_arburst);

    always_comb begin
        r_state_d = r_state_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rerr_d    = rerr_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        rd_idx    = ridx_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rd_idx    = axi_araddr[DEPTH_LOG2+1:2];
                    ridx_d    = rd_idx + idx_t'(1);
                    rid_d     = axi_arid;
                    rlen_d    = axi_arlen;
                    rbeat_d   = '0;
                    rerr_d    = ar_bad;
                    rresp_d   = ar_bad ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = ar_bad ? 32'h0 : rword;
                    rlast_d   = (axi_arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        ridx_d  = ridx_q + idx_t'(1);
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = rerr_q ? 32'h0 : rword;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE) && !stall;
        rvalid_d  = (r_state_d == R_DATA) &&
                    ((rvalid_q && !r_hs) || !stall);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
            rid_q     <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rerr_q    <= rerr_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rid     = rid_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;
    assign axi_rlast   = rlast_q;

endmodule
